// File: rtl/vga_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vga_pkg: shared video geometry, cell codes and decoder states   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package vga_pkg;

   localparam int unsigned VIDEO_W_DEFAULT = 640;
   localparam int unsigned VIDEO_H_DEFAULT = 480;

   // Index 0 is the left column / top row of the board.
   localparam logic [2:0][9:0] CELL_COLS_DEFAULT  = {10'd533, 10'd319, 10'd106};
   localparam logic [2:0][8:0] CELL_LINES_DEFAULT = {9'd400, 9'd240, 9'd80};

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      X     = 2'b01,
      O     = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      SEEK    = 2'b00,
      CAPTURE = 2'b01,
      COMMIT  = 2'b10
   } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_board_decoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vga_board_decoder_if: video input and decoded-board output bus  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface vga_board_decoder_if;

   logic                 iHS;
   logic                 iVS;
   logic                 iBLANK_n;
   logic [7:0]           iVGA_R;
   logic [7:0]           iVGA_G;
   logic [7:0]           iVGA_B;
   logic [2:0][2:0][1:0] oMATRIX;
   logic                 oFRAME_VALID;
   logic                 oSYNC_ERR;
   logic                 oLOCKED;

   modport master (
      output iHS, iVS, iBLANK_n, iVGA_R, iVGA_G, iVGA_B,
      input  oMATRIX, oFRAME_VALID, oSYNC_ERR, oLOCKED
   );

   modport slave (
      input  iHS, iVS, iBLANK_n, iVGA_R, iVGA_G, iVGA_B,
      output oMATRIX, oFRAME_VALID, oSYNC_ERR, oLOCKED
   );

endinterface
`default_nettype wire

// File: rtl/vga_pixel_classifier.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vga_pixel_classifier: maps one RGB pixel to a board cell code   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module vga_pixel_classifier
   import vga_pkg::*;
(
   input  logic [7:0] red_i,
   input  logic [7:0] green_i,
   input  logic [7:0] blue_i,
   output cell_t      cell_o
);

   logic r_hi;
   logic g_hi;
   logic b_hi;

   assign r_hi = (red_i   >= 8'h80);
   assign g_hi = (green_i >= 8'h80);
   assign b_hi = (blue_i  >= 8'h80);

   always_comb begin
      cell_o = EMPTY;
      if (r_hi && !g_hi && !b_hi) begin
         cell_o = X;
      end else if (b_hi && !r_hi && !g_hi) begin
         cell_o = O;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_board_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vga_board_decoder: samples a 3x3 board from VGA and validates   |
// | frame geometry before publishing it.  Rev 1.0                   |
// +-----------------------------------------------------------------+
module vga_board_decoder
   import vga_pkg::*;
#(
   parameter int unsigned     VIDEO_W     = VIDEO_W_DEFAULT,
   parameter int unsigned     VIDEO_H     = VIDEO_H_DEFAULT,
   parameter int unsigned     LOCK_FRAMES = 2,
   parameter logic [2:0][9:0] CELL_COLS   = CELL_COLS_DEFAULT,
   parameter logic [2:0][8:0] CELL_LINES  = CELL_LINES_DEFAULT
)(
   input  logic               iVGA_CLK,
   input  logic               iRST_n,
   vga_board_decoder_if.slave bus
);

   localparam int unsigned CNT_W   = $clog2(LOCK_FRAMES + 1);
   localparam logic [9:0]  COL_MAX = 10'd1023;
   localparam logic [8:0]  LIN_MAX = 9'd511;

   // Input registers
   logic       vs_q;
   logic       vs_d1_q;
   logic       blank_q;
   logic       blank_d1_q;
   logic [7:0] red_q;
   logic [7:0] green_q;
   logic [7:0] blue_q;

   // Decoder state
   state_t               state_q, state_d;
   logic [9:0]           col_q, col_d;
   logic [8:0]           line_q, line_d;
   logic                 bad_q, bad_d;
   logic [2:0][2:0][1:0] shadow_q, shadow_d;
   logic [2:0][2:0][1:0] matrix_q, matrix_d;
   logic                 frame_valid_q, frame_valid_d;
   logic                 sync_err_q, sync_err_d;
   logic [CNT_W-1:0]     good_q, good_d;

   logic       vs_fall;
   logic       blank_rise;
   logic       blank_fall;
   logic       line_ev;
   logic       enter_capture;
   logic [9:0] px_col;
   logic [2:0] col_hit;
   logic [2:0] line_hit;
   cell_t      px_cell;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         vs_q       <= 1'b1;
         vs_d1_q    <= 1'b1;
         blank_q    <= 1'b0;
         blank_d1_q <= 1'b0;
         red_q      <= '0;
         green_q    <= '0;
         blue_q     <= '0;
      end else begin
         vs_q       <= bus.iVS;
         vs_d1_q    <= vs_q;
         blank_q    <= bus.iBLANK_n;
         blank_d1_q <= blank_q;
         red_q      <= bus.iVGA_R;
         green_q    <= bus.iVGA_G;
         blue_q     <= bus.iVGA_B;
      end
   end

   assign vs_fall    = vs_d1_q & ~vs_q;
   assign blank_rise = blank_q & ~blank_d1_q;
   assign blank_fall = ~blank_q & blank_d1_q;
   // A line end that lands on the same sample as VS falling still counts.
   assign line_ev    = blank_fall & vs_d1_q;
   assign px_col     = blank_rise ? 10'd0 : col_q;

   vga_pixel_classifier u_classifier (
      .red_i   (red_q),
      .green_i (green_q),
      .blue_i  (blue_q),
      .cell_o  (px_cell)
   );

   always_comb begin
      col_hit  = '0;
      line_hit = '0;
      for (int i = 0; i < 3; i++) begin
         col_hit[i]  = (px_col == CELL_COLS[i]);
         line_hit[i] = (line_q == CELL_LINES[i]);
      end
   end

   always_comb begin
      state_d       = state_q;
      enter_capture = 1'b0;
      case (state_q)
         SEEK: begin
            if (vs_fall) begin
               state_d       = CAPTURE;
               enter_capture = 1'b1;
            end
         end
         CAPTURE: begin
            if (vs_fall) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d       = CAPTURE;
            enter_capture = 1'b1;
         end
         default: begin
            state_d = SEEK;
         end
      endcase
   end

   always_comb begin
      col_d = col_q;
      if (vs_q) begin
         if (blank_rise) begin
            col_d = 10'd1;
         end else if (blank_q && (col_q != COL_MAX)) begin
            col_d = col_q + 10'd1;
         end
      end
   end

   always_comb begin
      line_d        = line_q;
      bad_d         = bad_q;
      shadow_d      = shadow_q;
      matrix_d      = matrix_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      good_d        = good_q;

      if (enter_capture) begin
         line_d   = '0;
         bad_d    = 1'b0;
         shadow_d = '0;
      end else if (state_q == CAPTURE) begin
         if (line_ev) begin
            if (line_q != LIN_MAX) begin
               line_d = line_q + 9'd1;
            end
            if (col_q != 10'(VIDEO_W)) begin
               bad_d = 1'b1;
            end
         end
         if (vs_q && blank_q) begin
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  if (line_hit[r] && col_hit[c]) begin
                     shadow_d[r][c] = px_cell;
                  end
               end
            end
         end
      end

      // The shadow is read here before the exit from COMMIT clears it.
      if (state_q == COMMIT) begin
         if ((line_q == 9'(VIDEO_H)) && !bad_q) begin
            matrix_d      = shadow_q;
            frame_valid_d = 1'b1;
            if (good_q < CNT_W'(LOCK_FRAMES)) begin
               good_d = good_q + CNT_W'(1);
            end
         end else begin
            sync_err_d = 1'b1;
            good_d     = '0;
         end
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q       <= SEEK;
         col_q         <= '0;
         line_q        <= '0;
         bad_q         <= 1'b0;
         shadow_q      <= '0;
         matrix_q      <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         good_q        <= '0;
      end else begin
         state_q       <= state_d;
         col_q         <= col_d;
         line_q        <= line_d;
         bad_q         <= bad_d;
         shadow_q      <= shadow_d;
         matrix_q      <= matrix_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
         good_q        <= good_d;
      end
   end

   assign bus.oMATRIX      = matrix_q;
   assign bus.oFRAME_VALID = frame_valid_q;
   assign bus.oSYNC_ERR    = sync_err_q;
   assign bus.oLOCKED      = (good_q == CNT_W'(LOCK_FRAMES));

endmodule
`default_nettype wire

// File: doc/vga_board_decoder.md
VGA_BOARD_DECODER -- requirements
Module: vga_board_decoder

Interface
REQ-001 SHALL have parameter VIDEO_W, 640, active pixels per line.
REQ-002 SHALL have parameter VIDEO_H, 480, active lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, 2, consecutive good frames before lock.
REQ-004 Port: iVGA_CLK  in  1  pixel clock; the block's only clock.
REQ-005 Port: iRST_n  in  1  reset; asynchronous, active-low.
REQ-006 Port: iHS  in  1  horizontal sync, active-low.
REQ-007 Port: iVS  in  1  vertical sync, active-low.
REQ-008 Port: iBLANK_n  in  1  high during active pixels.
REQ-009 Port: iVGA_R / iVGA_G / iVGA_B  in  8 each  pixel colour.
REQ-010 Port: oMATRIX  out  [2:0][2:0][1:0]  decoded board, [row][col].
REQ-011 Port: oFRAME_VALID  out  1  one-cycle pulse when oMATRIX is updated.
REQ-012 Port: oSYNC_ERR  out  1  one-cycle pulse when a malformed frame is rejected.
REQ-013 Port: oLOCKED  out  1  high while LOCK_FRAMES consecutive good frames have been seen.

Function
REQ-014 All inputs SHALL be registered once; all edge detection SHALL use the registered copies.
REQ-015 Column counter (10 bit) SHALL clear on BLANK_n rising and increment per active pixel; it SHALL saturate at 1023.
REQ-016 Line counter (9 bit) SHALL increment on BLANK_n falling, clear on VS falling, and saturate at 511.
REQ-017 A line SHALL be flagged bad if its pixel count at BLANK_n falling is not VIDEO_W; a bad-line flag SHALL persist to frame end.
REQ-018 Pixels at column {106,319,533} and line {80,240,400} SHALL be classified and stored in the shadow cell [line index][column index].
REQ-019 Classification: R>=0x80, G<0x80, B<0x80 -> 2'b01 (X); B>=0x80, R<0x80, G<0x80 -> 2'b10 (O); otherwise 2'b00 (empty); 2'b11 SHALL never be produced.
REQ-020 FSM states: SEEK (wait for the first VS falling edge), CAPTURE (count and sample), COMMIT (one cycle, evaluate frame).
REQ-021 SEEK->CAPTURE on VS falling; CAPTURE->COMMIT on the next VS falling; COMMIT->CAPTURE unconditionally.
REQ-022 In COMMIT, a frame SHALL be good iff line count == VIDEO_H and no bad line was flagged.
REQ-023 A good frame SHALL copy shadow to oMATRIX and pulse oFRAME_VALID; a bad frame SHALL leave oMATRIX unchanged and pulse oSYNC_ERR.
REQ-024 oFRAME_VALID/oSYNC_ERR SHALL assert exactly 2 cycles after VS falling appears on iVS.
REQ-025 The good-frame counter SHALL saturate at LOCK_FRAMES; oLOCKED SHALL be high when it equals LOCK_FRAMES; a bad frame SHALL clear the counter and oLOCKED in the COMMIT cycle.
REQ-026 On simultaneous BLANK_n falling and VS falling, the line SHALL be counted and checked before the frame is evaluated.
REQ-027 The shadow SHALL be cleared to all 2'b00 on entry to CAPTURE; unsampled cells therefore read empty.
REQ-028 BLANK_n activity while VS is low SHALL be ignored by both counters.

Reset
REQ-029 iRST_n low SHALL asynchronously force: FSM=SEEK, counters=0, shadow=0, oMATRIX=0, oFRAME_VALID=0, oSYNC_ERR=0, oLOCKED=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no pulse SHALL follow release until a full frame is bracketed by two VS falling edges.

Structure
REQ-031 Package vga_pkg SHALL hold VIDEO_W/VIDEO_H defaults, the cell-centre column/line constants, the cell_t code enum (EMPTY, X, O), and the FSM state typedef.
REQ-032 Colour classification SHALL be a sub-module vga_pixel_classifier (RGB in, cell_t out, combinational); everything else SHALL be in vga_board_decoder.

Verification
REQ-033 Reset, two clean 640x480 frames, X at [0][0], O at [1][1], all else background (R=FF, G=FF, B=CC) -> oFRAME_VALID pulses twice, oMATRIX[0][0]=01, oMATRIX[1][1]=10, others 00, oLOCKED high after the 2nd pulse.
REQ-034 A frame with line 200 only 639 pixels long -> oSYNC_ERR pulses, oMATRIX retains the previous value, oLOCKED drops.
REQ-035 A frame of 479 lines -> oSYNC_ERR, with no oFRAME_VALID.
REQ-036 iRST_n low at line 300 of a frame, then released -> all outputs 0; the first oFRAME_VALID follows the second VS falling edge after release.
REQ-037 BLANK_n falling coincident with VS falling on line 480 -> frame accepted (oFRAME_VALID), pulse 2 cycles after the iVS edge.
REQ-038 Cell-centre pixel R=80, G=7F, B=7F -> 01; R=7F, G=7F, B=80 -> 10; R=G=B=80 -> 00.
